multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: ILLEGAL_HALT, default 0, meaning 1 = lock in HALT on illegal opcode, 0 = flag it and refetch.
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  7  instruction[6:0], taken from the instruction register.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 funct7b5  in  1  instruction[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 IorD  out  1  memory address select: 0 = pc, 1 = AluOut.
REQ-009 MemWrite  out  1  memory write strobe.
REQ-010 IRWrite  out  1  instruction register load.
REQ-011 PCWrite  out  1  PC load; taken-branch qualification is included.
REQ-012 RegWrite  out  1  register file write.
REQ-013 AluSrcA  out  2  ALU A select: 0 = pc, 1 = oldpc, 2 = rsA.
REQ-014 AluSrcB  out  2  ALU B select: 0 = rsB, 1 = imm, 2 = const 4.
REQ-015 ResultSrc  out  2  writeback select: 0 = AluOut, 1 = mem data, 2 = ALU result.
REQ-016 AluControl  out  4  ALU / memory operation code.
REQ-017 illegal  out  1  one-cycle pulse on an unsupported opcode or funct3.
REQ-018 state_dbg  out  4  current state encoding, for debug.

Function
REQ-019 The block SHALL be a Moore FSM with 13 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT.
- Exception: PCWrite in BRANCH depends on the zero input.
REQ-020 FETCH: IorD=0, IRWrite=1, AluSrcA=0, AluSrcB=2, AluControl=ADD, ResultSrc=2, PCWrite=1; next state DECODE.
REQ-021 DECODE: AluSrcA=1, AluSrcB=1, AluControl=ADD (branch target); next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 -> LUI
- any other opcode -> illegal handling per REQ-028.
REQ-022 MEMADR: AluSrcA=2, AluSrcB=1, AluControl=ADD; next state MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-023 MEMREAD: IorD=1, then MEMWB. MEMWB: ResultSrc=1, RegWrite=1, then FETCH.
REQ-024 MEMWRITE: IorD=1, MemWrite=1, AluControl=STORE (4'b1010), then FETCH; any funct3 other than 010 is illegal.
REQ-025 EXECR/EXECI: AluSrcA=2, AluSrcB=0 (EXECR) or 1 (EXECI), then ALUWB. ALUWB: ResultSrc=0, RegWrite=1, then FETCH.
- AluControl is decoded from funct3 and funct7b5; funct7b5 is honoured only for R-type and for funct3=101 I-type.
- funct3 to op: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-026 BRANCH: AluSrcA=2, AluSrcB=0, AluControl=SUB, ResultSrc=0; PCWrite = zero XOR funct3[0]; then FETCH.
- Only funct3 000 (beq) and 001 (bne) are supported; any other funct3 is illegal.
REQ-027 JAL: AluSrcA=1, AluSrcB=2, ResultSrc=0, PCWrite=1, then ALUWB. LUI: AluSrcA=2, AluSrcB=1, AluControl=PASSB, then ALUWB.
REQ-028 Illegal opcode or funct3: illegal=1 for exactly one cycle, the first cycle after DECODE.
- ILLEGAL_HALT=0: enter FETCH.
- ILLEGAL_HALT=1: enter HALT.
- HALT: every strobe is 0; HALT is left only by reset.
REQ-029 At most one of MemWrite, RegWrite, IRWrite SHALL be 1 in any cycle.
- MemWrite and RegWrite SHALL never be 1 in FETCH or DECODE.
REQ-030 Cycles per instruction:
- load 5
- store 4
- R-type / I-type 4
- branch 3
- jal 4
- lui 4.

Reset
REQ-031 While reset=0: state=FETCH, and all strobes (MemWrite, IRWrite, PCWrite, RegWrite, illegal) are 0. Selects and AluControl read 0.
REQ-032 After reset releases, the first rising edge SHALL execute FETCH.
- Asserting reset mid-instruction SHALL abort the instruction immediately; no write strobe may be asserted after that.

Structure
REQ-033 A shared package ctrl_pkg SHALL hold:
- the state enum
- opcode constants
- AluControl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, STORE 1010, PASSB 1011
- select encodings.
REQ-034 One combinational sub-module, alu_decoder, SHALL map (state class, funct3, funct7b5) to AluControl.

Verification
REQ-035 Reset: hold reset=0 for 8 ns, then release -> state_dbg=FETCH, IRWrite=1 and PCWrite=1 on the first edge.
REQ-036 Store: opcode=0100011, funct3=010 -> sequence FETCH, DECODE, MEMADR, MEMWRITE with MemWrite=1, IorD=1, AluControl=1010; 4 cycles total.
REQ-037 Load: opcode=0000011 -> RegWrite=1 with ResultSrc=1 only in cycle 5; MemWrite=0 throughout.
REQ-038 Branch:
- beq with zero=1 -> PCWrite=1 in cycle 3.
- bne with zero=1 -> PCWrite=0.
REQ-039 R-type: opcode=0110011, funct3=101, funct7b5=1 -> AluControl=1001 (SRA) in EXECR; RegWrite=1 in ALUWB.
REQ-040 Illegal opcode 1111111:
- ILLEGAL_HALT=0 -> one-cycle illegal pulse, then FETCH.
- ILLEGAL_HALT=1 -> HALT persists for 20 cycles with all strobes 0.
- Mid-MEMWRITE reset -> MemWrite=0 immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// ALU operation codes, datapath select encodings and the instruction legality check.
package ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    typedef enum logic [3:0] {
        ST_FETCH    = S_FETCH,
        ST_DECODE   = S_DECODE,
        ST_MEMADR   = S_MEMADR,
        ST_MEMREAD  = S_MEMREAD,
        ST_MEMWB    = S_MEMWB,
        ST_MEMWRITE = S_MEMWRITE,
        ST_EXECR    = S_EXECR,
        ST_EXECI    = S_EXECI,
        ST_ALUWB    = S_ALUWB,
        ST_BRANCH   = S_BRANCH,
        ST_JAL      = S_JAL,
        ST_LUI      = S_LUI,
        ST_HALT     = S_HALT
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_STORE = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS    = 2'd2;
    localparam logic [1:0] SRCB_RS    = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // Class of ALU operation a state requests; the decoder turns it into AluControl.
    localparam logic [2:0] AC_ADD   = 3'd0;
    localparam logic [2:0] AC_SUB   = 3'd1;
    localparam logic [2:0] AC_RTYPE = 3'd2;
    localparam logic [2:0] AC_ITYPE = 3'd3;
    localparam logic [2:0] AC_STORE = 3'd4;
    localparam logic [2:0] AC_PASSB = 3'd5;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_class;
    } ctrl_out_t;

    // Store accepts only word width; branches only beq/bne.
    function automatic logic instr_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OP_LOAD, OP_RTYPE, OP_ITYPE, OP_JAL, OP_LUI: ok = 1'b1;
            OP_STORE:  ok = (f3 == 3'b010);
            OP_BRANCH: ok = (f3[2:1] == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class requested by the current state, plus funct3/funct7b5,
// onto the 4-bit AluControl code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_class)
            AC_SUB:   alu_control = ALU_SUB;
            AC_STORE: alu_control = ALU_STORE;
            AC_PASSB: alu_control = ALU_PASSB;
            AC_RTYPE, AC_ITYPE: begin
                case (funct3)
                    // addi has no subtract form, so funct7b5 only matters for R-type here.
                    3'b000:  alu_control = (alu_class == AC_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32 subset datapath. Outputs are decoded from the
// state register and forced to zero while reset is asserted.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] ResultSrc,
    output logic [3:0] AluControl,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       illegal_q;
    logic       illegal_next;
    logic       decode_bad;
    ctrl_out_t  ctl;
    logic [3:0] alu_ctl;

    assign decode_bad = !instr_legal(opcode, funct3);

    always_comb begin
        state_next   = state;
        illegal_next = 1'b0;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (decode_bad) begin
                    illegal_next = 1'b1;
                    state_next   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_RTYPE:          state_next = S_EXECR;
                        OP_ITYPE:          state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_LUI:            state_next = S_LUI;
                        default:           state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_LUI:      state_next = S_ALUWB;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= illegal_next;
        end
    end

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.ir_write   = 1'b1;
                ctl.pc_write   = 1'b1;
                ctl.alu_src_a  = SRCA_PC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALU;
            end
            S_DECODE: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctl.alu_src_a = SRCA_RS;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: ctl.iord = 1'b1;
            S_MEMWB: begin
                ctl.result_src = RES_MEM;
                ctl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.alu_class = AC_STORE;
            end
            S_EXECR: begin
                ctl.alu_src_a = SRCA_RS;
                ctl.alu_src_b = SRCB_RS;
                ctl.alu_class = AC_RTYPE;
            end
            S_EXECI: begin
                ctl.alu_src_a = SRCA_RS;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_class = AC_ITYPE;
            end
            S_ALUWB: begin
                ctl.result_src = RES_ALUOUT;
                ctl.reg_write  = 1'b1;
            end
            // Branch target was parked in AluOut during DECODE; funct3[0] flips beq into bne.
            S_BRANCH: begin
                ctl.alu_src_a  = SRCA_RS;
                ctl.alu_src_b  = SRCB_RS;
                ctl.alu_class  = AC_SUB;
                ctl.result_src = RES_ALUOUT;
                ctl.pc_write   = zero ^ funct3[0];
            end
            S_JAL: begin
                ctl.alu_src_a  = SRCA_OLDPC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALUOUT;
                ctl.pc_write   = 1'b1;
            end
            S_LUI: begin
                ctl.alu_src_a = SRCA_RS;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_class = AC_PASSB;
            end
            default: ctl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class   (ctl.alu_class),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctl)
    );

    // Gating with the raw reset input kills every strobe the instant reset asserts.
    assign IorD       = reset & ctl.iord;
    assign MemWrite   = reset & ctl.mem_write;
    assign IRWrite    = reset & ctl.ir_write;
    assign PCWrite    = reset & ctl.pc_write;
    assign RegWrite   = reset & ctl.reg_write;
    assign AluSrcA    = reset ? ctl.alu_src_a : 2'b00;
    assign AluSrcB    = reset ? ctl.alu_src_b : 2'b00;
    assign ResultSrc  = reset ? ctl.result_src : 2'b00;
    assign AluControl = reset ? alu_ctl : 4'b0000;
    assign illegal    = reset & illegal_q;
    assign state_dbg  = state;

    a_write_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0({MemWrite, RegWrite, IRWrite}));

    a_no_early_write : assert property (@(posedge clk) disable iff (!reset)
        (state == S_FETCH || state == S_DECODE) |-> !(MemWrite || RegWrite));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle scripts feed an expected queue that
// one negedge process compares against the DUT; directed literals pin key cycles.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n, rst_h;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic funct7b5, zero;

    logic iord, mw, irw, pcw, rw, ill;
    logic [1:0] sa, sb, rs;
    logic [3:0] ac, st;
    logic iord_h, mw_h, irw_h, pcw_h, rw_h, ill_h;
    logic [1:0] sa_h, sb_h, rs_h;
    logic [3:0] ac_h, st_h;

    typedef struct packed {
        logic [3:0] st;
        logic iord, mw, irw, pcw, rw;
        logic [1:0] sa, sb, rs;
        logic [3:0] ac;
        logic ill;
    } cmp_t;

    // pcw: 0/1 literal, 2 = taken when zero ^ inv
    typedef struct packed {
        logic [3:0] st;
        logic iord, mw, irw;
        logic [1:0] pcw;
        logic rw;
        logic [1:0] sa, sb, rs;
        logic [3:0] ac;
        logic ill, inv;
    } exp_t;

    exp_t exp_q[$];
    cmp_t obs, obs_h;
    cmp_t cap [8];
    int n_vec = 0;
    int n_err = 0;
    logic running = 1'b0;
    logic pend_ill = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut (
        .clk(clk), .reset(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .IorD(iord), .MemWrite(mw), .IRWrite(irw), .PCWrite(pcw),
        .RegWrite(rw), .AluSrcA(sa), .AluSrcB(sb), .ResultSrc(rs), .AluControl(ac),
        .illegal(ill), .state_dbg(st)
    );

    multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .reset(rst_h), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .IorD(iord_h), .MemWrite(mw_h), .IRWrite(irw_h), .PCWrite(pcw_h),
        .RegWrite(rw_h), .AluSrcA(sa_h), .AluSrcB(sb_h), .ResultSrc(rs_h), .AluControl(ac_h),
        .illegal(ill_h), .state_dbg(st_h)
    );

    assign obs   = {st, iord, mw, irw, pcw, rw, sa, sb, rs, ac, ill};
    assign obs_h = {st_h, iord_h, mw_h, irw_h, pcw_h, rw_h, sa_h, sb_h, rs_h, ac_h, ill_h};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] s, input logic a_iord, input logic a_mw,
                                input logic a_irw, input logic [1:0] a_pcw, input logic a_rw,
                                input logic [1:0] a_sa, input logic [1:0] a_sb,
                                input logic [1:0] a_rs, input logic [3:0] a_ac);
        exp_t e;
        e = {s, a_iord, a_mw, a_irw, a_pcw, a_rw, a_sa, a_sb, a_rs, a_ac, 1'b0, 1'b0};
        return e;
    endfunction

    function automatic logic [3:0] model_alu(input logic is_r, input logic [2:0] f3, input logic f7);
        logic [3:0] base [8];
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f7 && f3 == 3'd5) return ALU_SRA;
        if (f7 && is_r && f3 == 3'd0) return ALU_SUB;
        return base[f3];
    endfunction

    // Pushes the expected cycle-by-cycle outputs of one instruction; returns its cycle count.
    function automatic int model_push(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        exp_t e;
        logic legal;
        e = mk(S_FETCH, 0, 0, 1, 2'd1, 0, SRCA_PC, SRCB_FOUR, RES_ALU, ALU_ADD);
        e.ill = pend_ill;
        pend_ill = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(mk(S_DECODE, 0, 0, 0, 2'd0, 0, SRCA_OLDPC, SRCB_IMM, RES_ALUOUT, ALU_ADD));
        legal = (opc == OP_LOAD) || (opc == OP_RTYPE) || (opc == OP_ITYPE) || (opc == OP_JAL) ||
                (opc == OP_LUI) || (opc == OP_STORE && f3 == 3'd2) || (opc == OP_BRANCH && f3 < 3'd2);
        if (!legal) begin
            pend_ill = 1'b1;
            return 2;
        end
        case (opc)
            OP_LOAD: begin
                exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 2'd0, 0, SRCA_RS, SRCB_IMM, 2'd0, ALU_ADD));
                exp_q.push_back(mk(S_MEMREAD, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, ALU_ADD));
                exp_q.push_back(mk(S_MEMWB, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, RES_MEM, ALU_ADD));
                return 5;
            end
            OP_STORE: begin
                exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 2'd0, 0, SRCA_RS, SRCB_IMM, 2'd0, ALU_ADD));
                exp_q.push_back(mk(S_MEMWRITE, 1, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, ALU_STORE));
                return 4;
            end
            OP_BRANCH: begin
                e = mk(S_BRANCH, 0, 0, 0, 2'd2, 0, SRCA_RS, SRCB_RS, RES_ALUOUT, ALU_SUB);
                e.inv = f3[0];
                exp_q.push_back(e);
                return 3;
            end
            OP_RTYPE: exp_q.push_back(mk(S_EXECR, 0, 0, 0, 2'd0, 0, SRCA_RS, SRCB_RS, 2'd0, model_alu(1'b1, f3, f7)));
            OP_ITYPE: exp_q.push_back(mk(S_EXECI, 0, 0, 0, 2'd0, 0, SRCA_RS, SRCB_IMM, 2'd0, model_alu(1'b0, f3, f7)));
            OP_JAL:   exp_q.push_back(mk(S_JAL, 0, 0, 0, 2'd1, 0, SRCA_OLDPC, SRCB_FOUR, RES_ALUOUT, ALU_ADD));
            default:  exp_q.push_back(mk(S_LUI, 0, 0, 0, 2'd0, 0, SRCA_RS, SRCB_IMM, 2'd0, ALU_PASSB));
        endcase
        exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, RES_ALUOUT, ALU_ADD));
        return 4;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cmp_t want;
        if (running) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL exp_q_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                want = {e.st, e.iord, e.mw, e.irw,
                        (e.pcw == 2'd2) ? (zero ^ e.inv) : e.pcw[0],
                        e.rw, e.sa, e.sb, e.rs, e.ac, e.ill};
                check("cycle", 32'(obs), 32'(want));
            end
        end
    end

    // force_zero < 0 randomises zero every cycle.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input int force_zero);
        int n;
        opcode = opc;
        funct3 = f3;
        funct7b5 = f7;
        n = model_push(opc, f3, f7);
        for (int k = 0; k < n; k++) begin
            zero = (force_zero < 0) ? 1'($urandom_range(0, 1)) : 1'(force_zero);
            @(negedge clk);
            if (k < 8) cap[k] = obs;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        int cls;
        rst_n = 1'b0;
        rst_h = 1'b0;
        opcode = 7'd0;
        funct3 = 3'd0;
        funct7b5 = 1'b0;
        zero = 1'b0;
        #4;
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_outputs_halt_inst", 32'(obs_h), 32'd0);
        #4;
        rst_n = 1'b1;
        running = 1'b1;

        run_instr(OP_STORE, 3'b010, 1'b0, -1);
        check("first_fetch", 32'({cap[0].st, cap[0].irw, cap[0].pcw}), 32'({S_FETCH, 2'b11}));
        check("store_seq", 32'({cap[0].st, cap[1].st, cap[2].st, cap[3].st}),
              32'({S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE}));
        check("store_memwrite", 32'({cap[3].mw, cap[3].iord, cap[3].ac}), 32'({2'b11, 4'b1010}));

        run_instr(OP_LOAD, 3'b010, 1'b0, -1);
        check("load_wb", 32'({cap[4].rw, cap[4].rs}), 32'({1'b1, 2'd1}));
        check("load_no_early_rw", 32'({cap[0].rw, cap[1].rw, cap[2].rw, cap[3].rw}), 32'd0);
        check("load_no_memwrite", 32'({cap[0].mw, cap[1].mw, cap[2].mw, cap[3].mw, cap[4].mw}), 32'd0);

        run_instr(OP_BRANCH, 3'b000, 1'b0, 1);
        check("beq_taken", 32'({cap[2].st, cap[2].pcw}), 32'({S_BRANCH, 1'b1}));
        run_instr(OP_BRANCH, 3'b001, 1'b0, 1);
        check("bne_not_taken", 32'({cap[2].st, cap[2].pcw}), 32'({S_BRANCH, 1'b0}));

        run_instr(OP_RTYPE, 3'b101, 1'b1, -1);
        check("rtype_sra", 32'({cap[2].st, cap[2].ac}), 32'({S_EXECR, 4'b1001}));
        check("rtype_wb", 32'({cap[3].st, cap[3].rw}), 32'({S_ALUWB, 1'b1}));

        run_instr(7'b1111111, 3'b000, 1'b0, -1);
        run_instr(OP_LUI, 3'b000, 1'b0, -1);
        check("illegal_pulse", 32'({cap[0].st, cap[0].ill, cap[1].ill}), 32'({S_FETCH, 2'b10}));
        check("lui_passb", 32'({cap[2].st, cap[2].ac}), 32'({S_LUI, 4'b1011}));

        for (int i = 0; i < 400; i++) begin
            cls = $urandom_range(0, 8);
            f3 = 3'($urandom_range(0, 7));
            case (cls)
                0: opc = OP_LOAD;
                1: begin
                    opc = OP_STORE;
                    if ($urandom_range(0, 3) != 0) f3 = 3'b010;
                end
                2: opc = OP_RTYPE;
                3: opc = OP_ITYPE;
                4: begin
                    opc = OP_BRANCH;
                    if ($urandom_range(0, 3) != 0) f3 = {2'b00, f3[0]};
                end
                5: opc = OP_JAL;
                6: opc = OP_LUI;
                7: opc = 7'($urandom_range(0, 127)) & 7'h7E;
                default: opc = 7'h7F;
            endcase
            run_instr(opc, f3, 1'($urandom_range(0, 1)), -1);
        end
        run_instr(OP_JAL, 3'b000, 1'b0, -1);
        running = 1'b0;

        opcode = OP_STORE;
        funct3 = 3'b010;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("memwrite_before_reset", 32'({st, mw}), 32'({S_MEMWRITE, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("memwrite_abort", 32'(obs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        opcode = 7'b1111111;
        @(negedge clk);
        rst_h = 1'b1;
        @(posedge clk);
        #1;
        check("halt_decode", 32'({st_h, ill_h}), 32'({S_DECODE, 1'b0}));
        @(posedge clk);
        #1;
        check("halt_entry", 32'({st_h, ill_h, mw_h, irw_h, pcw_h, rw_h}), 32'({S_HALT, 5'b10000}));
        opcode = OP_RTYPE;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("halt_hold", 32'({st_h, ill_h, mw_h, irw_h, pcw_h, rw_h}), 32'({S_HALT, 5'b00000}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
